seven_segment_capture: RTL
==========================

// Module: seven_segment_capture
// PURPOSE
//  Receive side of the multiplexed 4-digit seven-segment bus: snoops active-low Anodes/Segments.
//  Filters scan transitions and inverts the hex segment code back to nibbles.
//  Publishes a complete 4-digit frame. Used for on-board loopback checks and for display capture in benches.
// PARAMETERS
//  STABLE_CYCLES  16       consecutive identical samples needed to accept a digit (>=2)
//  STALE_CYCLES   1048576  cycles without a frame before Stale asserts
// PORTS
//  Clock          in   1   single clock, all logic rising-edge
//  Reset          in   1   synchronous, active-high
//  Anodes         in   4   active-low digit select; bit i low selects digit i
//  Segments       in   8   active-low {a,b,c,d,e,f,g,dp}; bit7=a, bit0=dp
//  Digits         out  16  digit i at [4i+3:4i]
//  DigitValid     out  4   1 = digit i decoded to a hex value
//  DecimalPoints  out  4   1 = dp of digit i lit
//  FrameValid     out  1   1-cycle pulse when Digits/DigitValid/DecimalPoints update
//  PatternError   out  1   1-cycle pulse on acceptance of an unknown non-blank pattern
//  Stale          out  1   no frame for STALE_CYCLES cycles
// BEHAVIOUR
//  Reset: all outputs 0; FSM=WAIT_SEL; stable counter, SeenMask, capture regs, stale counter cleared.
//  Input stage: {Anodes,Segments} registered into S (see CONFIGURATION); all logic below works on S.
//  FSM:
//   - WAIT_SEL: S.Anodes not exactly one low bit -> stay. Otherwise -> SETTLE with count=1.
//   - SETTLE: S unchanged -> count++. S changed -> count=1, or WAIT_SEL if no longer one-hot.
//     ACCEPT in the cycle count reaches STABLE_CYCLES -> HOLD.
//   - HOLD: S unchanged -> stay; no re-accept. S changed -> SETTLE (count=1) or WAIT_SEL.
//  ACCEPT for digit i, written to the capture regs on the next edge:
//   - seg[7:1] matches a hex code 0-F: nibble=value, valid=1.
//   - seg[7:1]=7'b1111111 (blank): nibble=0, valid=0, no error.
//   - Any other pattern: nibble=0, valid=0; PatternError pulses in the following cycle.
//   - dp=~seg[0] in all cases. SeenMask[i] is set.
//   - Re-accepting an already-seen digit overwrites it; the latest value wins.
//  Frame: when SeenMask (including the current accept) reaches 4'hF:
//   - next edge copies the capture regs to the outputs, pulses FrameValid, clears SeenMask.
//   - Outputs hold between frames; never partially updated.
//  Latency: last stable input change -> FrameValid = input-stage depth + STABLE_CYCLES + 1.
//  Stale: counter increments each cycle and saturates at STALE_CYCLES. Stale=1 at saturation.
//   FrameValid clears the counter and Stale in the same edge.
//  Reset mid-frame discards partial captures; no FrameValid until all 4 digits are re-accepted.
// CONFIGURATION
//  SEG_CAPTURE_SYNC_EN defined: 2-flop synchronizer per input bit (depth 2), for pin-level async capture.
//  Undefined: single register stage (depth 1), for on-chip same-clock loopback.
// STRUCTURE
//  Package seg_capture_pkg:
//   - localparams SEG_HEX[0:15] (7-bit active-low codes {a..g}) and SEG_BLANK=7'h7F
//   - state typedef {WAIT_SEL,SETTLE,HOLD}
//  Sub-module segment_pattern_lookup: combinational 7-bit pattern -> {hit,blank,nibble}.
//   Encodes the exact inverse of the hex display table:
//   - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
//   - 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000
// TESTING (STABLE_CYCLES=16, STALE_CYCLES=64, both macro settings)
//  1 Scan digits 0..3 (Anodes 1110/1101/1011/0111) for 20 cycles each, Segments 03/9F/25/0D
//    -> one FrameValid; Digits=16'h3210, DigitValid=4'hF, DecimalPoints=0.
//  2 Digit 1 held 10 cycles then switched -> no accept. After a full scan -> Digits[7:4] from the 20-cycle dwell only.
//  3 Digit 2 = 8'hFE (blank, dp on) -> DigitValid[2]=0, DecimalPoints[2]=1, no PatternError.
//    Digit 2 = 8'h7F -> PatternError pulse, DigitValid[2]=0.
//  4 Anodes=4'b1100 or 4'b1111 for 40 cycles -> no accept, FSM stays WAIT_SEL, no FrameValid.
//  5 Idle 64 cycles after reset -> Stale=1. Next full scan -> FrameValid and Stale=0 on the same edge.
//  6 Reset after digits 0,1 accepted, then scan only digits 2,3 -> no FrameValid.
//    Then scan digits 0,1 -> FrameValid.

Source files
------------

// File: rtl/seg_capture_pkg.sv
// Shared definitions for the seven-segment capture block: the active-low hex
// display table, the blank pattern, scan FSM states and anode-select helpers.
`timescale 1ns/1ps
package seg_capture_pkg;

    // Active-low {a,b,c,d,e,f,g} codes driven for nibble values 0..F.
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        WAIT_SEL,
        SETTLE,
        HOLD
    } state_t;

    function automatic logic sel_is_single(input logic [3:0] anodes);
        return (anodes == 4'b1110) || (anodes == 4'b1101) ||
               (anodes == 4'b1011) || (anodes == 4'b0111);
    endfunction

    function automatic logic [1:0] sel_index(input logic [3:0] anodes);
        logic [1:0] idx;
        case (anodes)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/segment_pattern_lookup.sv
// Combinational inverse of the hex display table: 7-bit active-low pattern
// to {hit, blank, nibble}. Unknown patterns give hit=0, blank=0, nibble=0.
`timescale 1ns/1ps
module segment_pattern_lookup
    import seg_capture_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic       o_hit,
    output logic       o_blank,
    output logic [3:0] o_nibble
);

    logic [15:0] w_match;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_match
            assign w_match[gi] = (i_pattern == SEG_HEX[gi]);
        end
    endgenerate

    // Table entries are distinct, so at most one match bit is ever set.
    always_comb begin
        o_nibble = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (w_match[k]) begin
                o_nibble = 4'(k);
            end
        end
    end

    assign o_hit   = |w_match;
    assign o_blank = (i_pattern == SEG_BLANK);

endmodule

// File: rtl/seven_segment_capture.sv
// Snoops a multiplexed active-low 4-digit seven-segment bus and publishes whole
// decoded frames. Define SEG_CAPTURE_SYNC_EN for a 2-flop input synchronizer.
`timescale 1ns/1ps
module seven_segment_capture
    import seg_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int STALE_CYCLES  = 1048576
)
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_anodes,
    input  logic [7:0]  i_segments,
    output logic [15:0] o_digits,
    output logic [3:0]  o_digit_valid,
    output logic [3:0]  o_decimal_points,
    output logic        o_frame_valid,
    output logic        o_pattern_error,
    output logic        o_stale
);

    localparam int CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);

    logic [11:0] w_pins;
    logic [11:0] r_s;
    logic [11:0] r_s_prev;

    assign w_pins = {i_anodes, i_segments};

`ifdef SEG_CAPTURE_SYNC_EN
    logic [11:0] r_meta;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 12'hFFF;
            r_s    <= 12'hFFF;
        end else begin
            r_meta <= w_pins;
            r_s    <= r_meta;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s <= 12'hFFF;
        end else begin
            r_s <= w_pins;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s_prev <= 12'hFFF;
        end else begin
            r_s_prev <= r_s;
        end
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             w_same;
    logic             w_sel_ok;
    logic             w_accept;

    assign w_same   = (r_s == r_s_prev);
    assign w_sel_ok = sel_is_single(r_s[11:8]);
    assign w_accept = (r_state == SETTLE) && (r_count == CNT_W'(STABLE_CYCLES));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= WAIT_SEL;
            r_count <= '0;
        end else begin
            case (r_state)
                WAIT_SEL: begin
                    if (w_sel_ok) begin
                        r_state <= SETTLE;
                        r_count <= CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (w_same && w_accept) begin
                        r_state <= HOLD;
                    end else if (w_same) begin
                        r_count <= r_count + 1'b1;
                    end else if (w_sel_ok) begin
                        r_count <= CNT_W'(1);
                    end else begin
                        r_state <= WAIT_SEL;
                    end
                end
                HOLD: begin
                    if (!w_same) begin
                        if (w_sel_ok) begin
                            r_state <= SETTLE;
                            r_count <= CNT_W'(1);
                        end else begin
                            r_state <= WAIT_SEL;
                        end
                    end
                end
                default: begin
                    r_state <= WAIT_SEL;
                end
            endcase
        end
    end

    // The accepted sample is r_s_prev: it is the one proven stable by the count.
    logic [1:0] w_idx;
    logic       w_hit;
    logic       w_blank;
    logic [3:0] w_nibble;

    assign w_idx = sel_index(r_s_prev[11:8]);

    segment_pattern_lookup u_lookup (
        .i_pattern (r_s_prev[7:1]),
        .o_hit     (w_hit),
        .o_blank   (w_blank),
        .o_nibble  (w_nibble)
    );

    logic [15:0] r_cap_digits;
    logic [3:0]  r_cap_valid;
    logic [3:0]  r_cap_dp;
    logic [3:0]  r_seen;
    logic [15:0] w_cap_digits_next;
    logic [3:0]  w_cap_valid_next;
    logic [3:0]  w_cap_dp_next;
    logic [3:0]  w_seen_next;
    logic [3:0]  w_write;
    logic        w_frame;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign w_write[gi] = w_accept && (w_idx == 2'(gi));
            assign w_cap_digits_next[4*gi +: 4] = w_write[gi] ? (w_hit ? w_nibble : 4'h0)
                                                              : r_cap_digits[4*gi +: 4];
            assign w_cap_valid_next[gi] = w_write[gi] ? w_hit          : r_cap_valid[gi];
            assign w_cap_dp_next[gi]    = w_write[gi] ? ~r_s_prev[0]   : r_cap_dp[gi];
            assign w_seen_next[gi]      = w_write[gi] | r_seen[gi];
        end
    endgenerate

    assign w_frame = w_accept && (w_seen_next == 4'hF);

    logic [15:0] r_digits;
    logic [3:0]  r_digit_valid;
    logic [3:0]  r_decimal_points;
    logic        r_frame_valid;
    logic        r_pattern_error;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cap_digits     <= '0;
            r_cap_valid      <= '0;
            r_cap_dp         <= '0;
            r_seen           <= '0;
            r_digits         <= '0;
            r_digit_valid    <= '0;
            r_decimal_points <= '0;
            r_frame_valid    <= 1'b0;
            r_pattern_error  <= 1'b0;
        end else begin
            r_cap_digits    <= w_cap_digits_next;
            r_cap_valid     <= w_cap_valid_next;
            r_cap_dp        <= w_cap_dp_next;
            r_frame_valid   <= w_frame;
            r_pattern_error <= w_accept && !w_hit && !w_blank;
            if (w_frame) begin
                r_digits         <= w_cap_digits_next;
                r_digit_valid    <= w_cap_valid_next;
                r_decimal_points <= w_cap_dp_next;
                r_seen           <= '0;
            end else begin
                r_seen <= w_seen_next;
            end
        end
    end

    logic [STALE_W-1:0] r_stale_cnt;
    logic               r_stale;

    always_ff @(posedge i_clk) begin
        if (i_reset || w_frame) begin
            r_stale_cnt <= '0;
            r_stale     <= 1'b0;
        end else if (r_stale_cnt != STALE_W'(STALE_CYCLES)) begin
            r_stale_cnt <= r_stale_cnt + 1'b1;
            r_stale     <= (r_stale_cnt == STALE_W'(STALE_CYCLES - 1));
        end
    end

    assign o_digits         = r_digits;
    assign o_digit_valid    = r_digit_valid;
    assign o_decimal_points = r_decimal_points;
    assign o_frame_valid    = r_frame_valid;
    assign o_pattern_error  = r_pattern_error;
    assign o_stale          = r_stale;

endmodule
